dc_offset_remove: RTL and testbench
===================================

// Module: dc_offset_remove
// PURPOSE
//  Downstream consumer of the 2048-sample mean stage. Subtracts the most recent frame mean
//  (Q1.15) from the live Q1.15 sample stream, saturating to Q1.15, so later stages see
//  DC-free data. New means are applied only at frame boundaries. Output is a
//  2-stage valid/ready pipeline with backpressure.
// PARAMETERS
//  DATA_W     16    sample/mean width, Q1.15 two's complement
//  FRAME_LEN  2048  accepted samples per frame; offset switches only on frame wrap
//  IIR_SHIFT  3     smoothing shift, used only when DC_IIR_EN is defined
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       reset, asynchronous, active-low
//  mean_valid   in   1       mean_in valid (single-cycle pulse from mean stage)
//  mean_in      in   DATA_W  frame mean, Q1.15
//  s_valid      in   1       input sample valid
//  s_ready      out  1       input sample accepted when s_valid & s_ready
//  s_data       in   DATA_W  input sample, Q1.15
//  m_valid      out  1       output sample valid
//  m_ready      in   1       downstream ready
//  m_data       out  DATA_W  s_data - offset, saturated Q1.15
//  m_sat        out  1       m_data was clipped (aligned with m_data)
//  mean_locked  out  1       1 once a mean has been applied (state RUN)
// BEHAVIOUR
//  - Reset (async, rst=0): m_valid=0, m_data=0, m_sat=0, mean_locked=0, offset=0,
//    pend_flag=0, frame_cnt=0, state=WAIT_MEAN, both pipe stages empty. s_ready=1 after reset.
//  - Handshake: adv = !m_valid | m_ready; s_ready = adv (combinational). Both stages
//    shift on adv. Accept = s_valid & s_ready. m_data/m_valid stable while m_valid & !m_ready.
//  - Latency: 2 cycles accept->m_valid with m_ready=1; full throughput 1 sample/cycle.
//  - Stage1: diff[DATA_W:0] = sext(s_data) - sext(offset), offset sampled in accept cycle.
//  - Stage2: diff>32767 -> 0x7FFF, m_sat=1; diff<-32768 -> 0x8000, m_sat=1; else diff[15:0].
//  - Pending mean: mean_valid loads pend_mean<=mean_in, pend_flag<=1; a later pulse before
//    use overwrites. mean_valid in the same cycle as consumption: new value wins, pend stays 1.
//  - frame_cnt counts accepts, 0..FRAME_LEN-1, wraps to 0; never counts unaccepted cycles.
//  - FSM WAIT_MEAN: offset=0 (pass-through). On pend_flag=1 -> offset<=pend_mean,
//    pend_flag<=0, frame_cnt<=0, -> RUN, mean_locked<=1. Sample accepted in that cycle uses old offset 0.
//  - FSM RUN: on accept with frame_cnt==FRAME_LEN-1 and pend_flag=1 -> offset updated,
//    pend_flag<=0; effective from the next accepted sample. No other offset changes.
//  - mean_valid with s_valid=0 never changes frame_cnt; no RUN->WAIT_MEAN except reset.
//  - Reset mid-frame: pipeline contents dropped, no partial output emitted.
// CONFIGURATION
//  DC_IIR_EN defined: RUN-state frame-boundary update becomes
//    offset <= offset + ((pend_mean - offset) >>> IIR_SHIFT), 17-bit signed intermediate,
//    result always in range; WAIT_MEAN->RUN load stays direct.
//  DC_IIR_EN undefined: direct load offset <= pend_mean; IIR_SHIFT ignored.
// TESTING
//  1 Reset, s_data=0x1000 streaming, no mean -> m_data=0x1000 two cycles later, mean_locked=0.
//  2 mean_valid, mean_in=0x0100 in WAIT_MEAN, then s_data=0x1000 -> m_data=0x0F00, mean_locked=1.
//  3 offset=0x8000, s_data=0x7FFF -> 0x7FFF, m_sat=1; offset=0x7FFF, s_data=0x8000 -> 0x8000, m_sat=1.
//  4 RUN offset 0x0100, mean_valid 0x0200 at frame_cnt=100 -> samples to cnt 2047 use 0x0100,
//    first sample of next frame uses 0x0200 (DC_IIR_EN: 0x0120 with IIR_SHIFT=3).
//  5 Random m_ready (30% low), 4096 random samples -> output matches model, no loss/dup,
//    m_data stable while stalled.
//  6 rst pulse low at frame_cnt=700 with full pipe -> all outputs 0 immediately, WAIT_MEAN,
//    next sample passes unmodified.

Source files
------------

// File: rtl/dc_offset_remove.sv
// Removes the latest frame mean from a Q1.15 sample stream through a 2-stage saturating pipe.
// Optional define DC_IIR_EN smooths frame-boundary offset updates with a shift-based IIR.
module dc_offset_remove #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAME_LEN = 2048,
  parameter int unsigned IIR_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mean_valid,
  input  logic [DATA_W-1:0] i_mean_in,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_sat,
  output logic              o_mean_locked
);

  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {StWaitMean, StRun} state_e;

  state_e              r_state, w_state_next;
  logic [DATA_W-1:0]   r_offset, w_offset_next;
  logic [DATA_W-1:0]   r_pend_mean, w_pend_mean_next;
  logic                r_pend_flag, w_pend_flag_next;
  logic [CNT_W-1:0]    r_frame_cnt, w_frame_cnt_next;
  logic                r_locked, w_locked_next;

  logic                r_s1_valid;
  logic [DATA_W:0]     r_s1_diff;
  logic                r_m_valid;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_sat;

  logic                w_adv;
  logic                w_accept;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_sat_data;
  logic                w_sat_flag;
  logic [DATA_W-1:0]   w_run_offset;

  assign w_adv    = !r_m_valid || i_m_ready;
  assign w_accept = i_s_valid && w_adv;
  assign w_diff   = {i_s_data[DATA_W-1], i_s_data} - {r_offset[DATA_W-1], r_offset};

  // Overflow shows up as disagreement between the two top bits of the 17-bit difference.
  always_comb begin
    w_sat_data = r_s1_diff[DATA_W-1:0];
    w_sat_flag = 1'b0;
    if (r_s1_diff[DATA_W] != r_s1_diff[DATA_W-1]) begin
      w_sat_flag = 1'b1;
      w_sat_data = r_s1_diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

`ifdef DC_IIR_EN
  logic signed [DATA_W:0] w_iir_delta;
  logic signed [DATA_W:0] w_iir_step;
  logic signed [DATA_W:0] w_iir_sum;
  logic                   w_unused_iir_msb;

  assign w_iir_delta = $signed({r_pend_mean[DATA_W-1], r_pend_mean})
                     - $signed({r_offset[DATA_W-1], r_offset});
  assign w_iir_step  = w_iir_delta >>> IIR_SHIFT;
  assign w_iir_sum   = $signed({r_offset[DATA_W-1], r_offset}) + w_iir_step;
  // The step never overshoots the target, so the sum always fits in DATA_W bits.
  assign w_run_offset     = w_iir_sum[DATA_W-1:0];
  assign w_unused_iir_msb = w_iir_sum[DATA_W];
`else
  logic w_unused_iir_shift;
  assign w_run_offset       = r_pend_mean;
  assign w_unused_iir_shift = ^IIR_SHIFT;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_offset_next    = r_offset;
    w_pend_mean_next = r_pend_mean;
    w_pend_flag_next = r_pend_flag;
    w_frame_cnt_next = r_frame_cnt;
    w_locked_next    = r_locked;

    if (w_accept) begin
      w_frame_cnt_next = (r_frame_cnt == CNT_LAST) ? '0 : r_frame_cnt + 1'b1;
    end

    unique case (r_state)
      StWaitMean: begin
        if (r_pend_flag) begin
          w_offset_next    = r_pend_mean;
          w_pend_flag_next = 1'b0;
          w_frame_cnt_next = '0;
          w_locked_next    = 1'b1;
          w_state_next     = StRun;
        end
      end
      StRun: begin
        if (w_accept && (r_frame_cnt == CNT_LAST) && r_pend_flag) begin
          w_offset_next    = w_run_offset;
          w_pend_flag_next = 1'b0;
        end
      end
      default: w_state_next = StWaitMean;
    endcase

    // A fresh mean arriving in the consumption cycle survives as the next pending value.
    if (i_mean_valid) begin
      w_pend_mean_next = i_mean_in;
      w_pend_flag_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StWaitMean;
      r_offset    <= '0;
      r_pend_mean <= '0;
      r_pend_flag <= 1'b0;
      r_frame_cnt <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_offset    <= w_offset_next;
      r_pend_mean <= w_pend_mean_next;
      r_pend_flag <= w_pend_flag_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_locked    <= w_locked_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_diff  <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_sat    <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      r_s1_diff  <= w_diff;
      r_m_valid  <= r_s1_valid;
      r_m_data   <= w_sat_data;
      r_m_sat    <= w_sat_flag;
    end
  end

  assign o_s_ready     = w_adv;
  assign o_m_valid     = r_m_valid;
  assign o_m_data      = r_m_data;
  assign o_m_sat       = r_m_sat;
  assign o_mean_locked = r_locked;

endmodule

// File: tb/tb_dc_offset_remove.sv
// Scoreboard bench for dc_offset_remove: stimulus pushes expected {sat,data}, a monitor pops.
module tb_dc_offset_remove;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_mean_valid = 1'b0;
  logic [15:0] i_mean_in = '0;
  logic        i_s_valid = 1'b0;
  logic        o_s_ready;
  logic [15:0] i_s_data = '0;
  logic        o_m_valid;
  logic        i_m_ready = 1'b1;
  logic [15:0] o_m_data;
  logic        o_m_sat;
  logic        o_mean_locked;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [16:0] exp_q[$];
  logic        rand_en = 1'b0;
  logic        force_ready = 1'b1;
  logic        stall_prev = 1'b0;
  logic [16:0] stall_val = '0;

  dc_offset_remove dut (
    .clk          (clk),
    .rst          (rst),
    .i_mean_valid (i_mean_valid),
    .i_mean_in    (i_mean_in),
    .i_s_valid    (i_s_valid),
    .o_s_ready    (o_s_ready),
    .i_s_data     (i_s_data),
    .o_m_valid    (o_m_valid),
    .i_m_ready    (i_m_ready),
    .o_m_data     (o_m_data),
    .o_m_sat      (o_m_sat),
    .o_mean_locked(o_mean_locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    i_m_ready = rand_en ? ($urandom_range(0, 9) >= 3) : force_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {sat, data} for s - off with Q1.15 saturation.
  function automatic logic [16:0] model(input logic [15:0] s, input logic [15:0] off);
    int d;
    d = $signed(s) - $signed(off);
    if (d > 32767) return {1'b1, 16'h7FFF};
    if (d < -32768) return {1'b1, 16'h8000};
    return {1'b0, d[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && o_m_valid) begin
        n_checks++;
        if ({o_m_sat, o_m_data} !== stall_val) begin
          n_fail++;
          $display("FAIL stall_hold: got %0h expected %0h", {o_m_sat, o_m_data}, stall_val);
        end
      end
      if (o_m_valid && i_m_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", {o_m_sat, o_m_data});
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if ({o_m_sat, o_m_data} !== e) begin
            n_fail++;
            $display("FAIL output: got sat=%0b data=%h expected sat=%0b data=%h",
                     o_m_sat, o_m_data, e[16], e[15:0]);
          end
        end
      end
      stall_prev = o_m_valid && !i_m_ready;
      stall_val  = {o_m_sat, o_m_data};
    end
  end

  task automatic send(input logic [15:0] d, input logic [16:0] e);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    i_s_valid = 1'b1;
    i_s_data  = d;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = o_s_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (acc) exp_q.push_back(e);
    else check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    i_s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_mean(input logic [15:0] v);
    i_s_valid    = 1'b0;
    i_mean_valid = 1'b1;
    i_mean_in    = v;
    @(posedge clk);
    #1;
    i_mean_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    i_s_valid = 1'b0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    i_s_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_m_valid", 32'(o_m_valid), 32'd0);
    check("rst_m_data", 32'(o_m_data), 32'd0);
    check("rst_m_sat", 32'(o_m_sat), 32'd0);
    check("rst_locked", 32'(o_mean_locked), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_s_ready", 32'(o_s_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] d;
    do_reset();

    // Pass-through before any mean.
    send(16'h1000, {1'b0, 16'h1000});
    send(16'h1000, {1'b0, 16'h1000});
    drain();
    check("locked_before_mean", 32'(o_mean_locked), 32'd0);

    // Mean 0x0100 applied from WAIT; this sample is frame index 0.
    pulse_mean(16'h0100);
    check("locked_after_mean", 32'(o_mean_locked), 32'd1);
    send(16'h1000, {1'b0, 16'h0F00});

    // Pending mean at index 100 takes effect only at the next frame.
    for (int i = 1; i < 2048; i++) begin
      if (i == 100) pulse_mean(16'h0200);
      d = 16'(i * 13);
      send(d, model(d, 16'h0100));
    end
`ifdef DC_IIR_EN
    send(16'h1000, {1'b0, 16'h0EE0});
    send(16'h0000, {1'b0, 16'hFEE0});
`else
    send(16'h1000, {1'b0, 16'h0E00});
    send(16'h0000, {1'b0, 16'hFE00});
`endif
    drain();

    // Saturation corners.
    do_reset();
    pulse_mean(16'h8000);
    send(16'h7FFF, {1'b1, 16'h7FFF});
    send(16'h0000, {1'b1, 16'h7FFF});
    send(16'h8000, {1'b0, 16'h0000});
    drain();
    do_reset();
    pulse_mean(16'h7FFF);
    send(16'h8000, {1'b1, 16'h8000});
    send(16'hFFFF, {1'b0, 16'h8000});
    send(16'h7FFF, {1'b0, 16'h0000});
    drain();

    // Random backpressure with random data.
    do_reset();
    pulse_mean(16'h1234);
    rand_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      d = 16'($urandom);
      send(d, model(d, 16'h1234));
    end
    drain();
    rand_en = 1'b0;
    force_ready = 1'b1;
    idle(2);

    // Reset mid-frame with a full, stalled pipe.
    for (int i = 0; i < 698; i++) begin
      d = 16'(i * 5);
      send(d, model(d, 16'h1234));
    end
    drain();
    force_ready = 1'b0;
    idle(2);
    send(16'h2222, 17'h0);
    send(16'h3333, 17'h0);
    check("pipe_full_valid", 32'(o_m_valid), 32'd1);
    do_reset();
    force_ready = 1'b1;
    idle(2);
    send(16'h1234, {1'b0, 16'h1234});
    drain();
    check("locked_after_reset", 32'(o_mean_locked), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
